// File: rtl/aes_link_pkg.sv
// Shared definitions for the AES SPI link frame engine.
package aes_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_BLOCK,
    ST_RX_SIZE,
    ST_RX_KEY,
    ST_CRYPT,
    ST_TX_STATUS,
    ST_TX_RESULT,
    ST_ERROR
  } state_t;

  // Key size byte values (low 7 bits of the size/mode byte), in bytes
  localparam logic [7:0] SIZE_128 = 8'd16;
  localparam logic [7:0] SIZE_192 = 8'd24;
  localparam logic [7:0] SIZE_256 = 8'd32;

  // Bit of the size/mode byte selecting decryption
  localparam int unsigned DECRYPT_BIT = 7;

  typedef enum logic [1:0] {
    KS_128 = 2'd0,
    KS_192 = 2'd1,
    KS_256 = 2'd2
  } key_size_t;

  localparam logic [7:0] STATUS_BUSY  = 8'h00;
  localparam logic [7:0] STATUS_READY = 8'h01;
  localparam logic [7:0] ERR_BYTE     = 8'hEE;

endpackage

// File: rtl/aes_frame_shreg.sv
// Byte-indexed load register with synchronous clear; byte idx lands in q[idx*8 +: 8].
module aes_frame_shreg #(
  parameter int unsigned WIDTH = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr,
  input  logic                           load,
  input  logic [$clog2(WIDTH/8)-1:0]     idx,
  input  logic [7:0]                     din,
  output logic [WIDTH-1:0]               q
);

  // Clear has priority over a byte load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q[{idx, 3'b000} +: 8] <= din;
    end
  end

endmodule

// File: rtl/aes_spi_frame_responder.sv
// Slave-side SPI frame engine: collects block/size/key, runs the AES core,
// then answers polling bytes with status and the 16 result bytes.
module aes_spi_frame_responder
  import aes_link_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         cs_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic [7:0]   tx_data,
  output logic         aes_start,
  output logic         aes_decrypt,
  output logic [1:0]   aes_key_size,
  output logic [255:0] aes_key,
  output logic [127:0] aes_block_in,
  input  logic         aes_done,
  input  logic [127:0] aes_block_out,
  output logic         busy,
  output logic         frame_err
);

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [7:0]   tx_d;
  logic         start_d, dec_d, busy_d, ferr_d;
  logic [1:0]   ks_d;
  logic [127:0] result_q;
  logic         result_ld;
  logic         key_clr, key_ld, blk_ld;
  logic [3:0]   blk_idx;
  logic         size_ok;
  logic [1:0]   size_code;

  aes_frame_shreg #(.WIDTH(256)) u_key_reg (
    .clk   (clk),
    .reset (reset),
    .clr   (key_clr),
    .load  (key_ld),
    .idx   (cnt_q),
    .din   (rx_data),
    .q     (aes_key)
  );

  aes_frame_shreg #(.WIDTH(128)) u_block_reg (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .load  (blk_ld),
    .idx   (blk_idx),
    .din   (rx_data),
    .q     (aes_block_in)
  );

  // Decode the size/mode byte
  always_comb begin
    size_ok   = 1'b0;
    size_code = KS_128;
    case ({1'b0, rx_data[6:0]})
      SIZE_128: begin size_ok = 1'b1; size_code = KS_128; end
      SIZE_192: begin size_ok = 1'b1; size_code = KS_192; end
      SIZE_256: begin size_ok = 1'b1; size_code = KS_256; end
      default:  begin size_ok = 1'b0; size_code = KS_128; end
    endcase
  end

  // Next-state and datapath control; a high cs_n aborts from any state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_d      = tx_data;
    start_d   = 1'b0;
    dec_d     = aes_decrypt;
    ks_d      = aes_key_size;
    busy_d    = busy;
    ferr_d    = frame_err;
    result_ld = 1'b0;
    key_clr   = 1'b0;
    key_ld    = 1'b0;
    blk_ld    = 1'b0;
    blk_idx   = cnt_q[3:0];
    if (cs_n) begin
      state_d = ST_IDLE;
      tx_d    = STATUS_BUSY;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_valid) begin
          blk_ld  = 1'b1;
          blk_idx = 4'd15;
          cnt_d   = 5'd14;
          busy_d  = 1'b1;
          ferr_d  = 1'b0;
          state_d = ST_RX_BLOCK;
        end
        ST_RX_BLOCK: if (rx_valid) begin
          blk_ld = 1'b1;
          if (cnt_q == 5'd0) state_d = ST_RX_SIZE;
          else               cnt_d   = cnt_q - 5'd1;
        end
        ST_RX_SIZE: if (rx_valid) begin
          if (size_ok) begin
            dec_d   = rx_data[DECRYPT_BIT];
            ks_d    = size_code;
            key_clr = 1'b1;
            cnt_d   = rx_data[4:0] - 5'd1;
            state_d = ST_RX_KEY;
          end else begin
            ferr_d  = 1'b1;
            tx_d    = ERR_BYTE;
            state_d = ST_ERROR;
          end
        end
        ST_RX_KEY: if (rx_valid) begin
          key_ld = 1'b1;
          if (cnt_q == 5'd0) begin
            start_d = 1'b1;
            state_d = ST_CRYPT;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        ST_CRYPT: begin
          tx_d = STATUS_BUSY;
          if (aes_done) begin
            result_ld = 1'b1;
            tx_d      = STATUS_READY;
            state_d   = ST_TX_STATUS;
          end
        end
        ST_TX_STATUS: if (rx_valid) begin
          tx_d    = result_q[127:120];
          cnt_d   = 5'd15;
          state_d = ST_TX_RESULT;
        end
        ST_TX_RESULT: if (rx_valid) begin
          if (cnt_q == 5'd0) begin
            tx_d    = STATUS_BUSY;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 5'd1;
            tx_d  = result_q[{cnt_d[3:0], 3'b000} +: 8];
          end
        end
        ST_ERROR: tx_d = ERR_BYTE;
        default: begin
          state_d = ST_IDLE;
          tx_d    = STATUS_BUSY;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tx_data      <= STATUS_BUSY;
      aes_start    <= 1'b0;
      aes_decrypt  <= 1'b0;
      aes_key_size <= '0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_data      <= tx_d;
      aes_start    <= start_d;
      aes_decrypt  <= dec_d;
      aes_key_size <= ks_d;
      busy         <= busy_d;
      frame_err    <= ferr_d;
      if (result_ld) result_q <= aes_block_out;
    end
  end

endmodule

// File: tb/tb_aes_spi_frame_responder.sv
// Self-checking bench for aes_spi_frame_responder: the bench plays SPI master
// and AES core, and checks every byte the master receives.
module tb_aes_spi_frame_responder;

  logic         clk;
  logic         reset;
  logic         cs_n;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic [7:0]   tx_data;
  logic         aes_start;
  logic         aes_decrypt;
  logic [1:0]   aes_key_size;
  logic [255:0] aes_key;
  logic [127:0] aes_block_in;
  logic         aes_done;
  logic [127:0] aes_block_out;
  logic         busy;
  logic         frame_err;

  aes_spi_frame_responder dut (
    .clk          (clk),
    .reset        (reset),
    .cs_n         (cs_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .aes_start    (aes_start),
    .aes_decrypt  (aes_decrypt),
    .aes_key_size (aes_key_size),
    .aes_key      (aes_key),
    .aes_block_in (aes_block_in),
    .aes_done     (aes_done),
    .aes_block_out(aes_block_out),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_count = 0;

  // Count start pulses (sampled on the inactive edge)
  always @(negedge clk) if (aes_start) start_count++;

  typedef struct {
    logic [127:0] block;
    logic [7:0]   size_byte;
    logic [255:0] key;
    logic [127:0] result;
  } kat_t;

  kat_t kat [6];

  // Stand-in AES core: known-answer vectors, otherwise an arbitrary mix
  function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic [255:0] key,
                                           input logic [7:0] size_byte);
    for (int i = 0; i < 6; i++)
      if (kat[i].block == blk && kat[i].key == key && kat[i].size_byte == size_byte)
        return kat[i].result;
    return {blk[63:0], blk[127:64]} ^ key[255:128] ^ key[127:0] ^ {120'd0, size_byte};
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_tx",    256'(tx_data),      256'(8'h00));
    chk("rst_start", 256'(aes_start),    256'(1'b0));
    chk("rst_dec",   256'(aes_decrypt),  256'(1'b0));
    chk("rst_ks",    256'(aes_key_size), 256'(2'd0));
    chk("rst_key",   aes_key,            256'(0));
    chk("rst_block", 256'(aes_block_in), 256'(0));
    chk("rst_busy",  256'(busy),         256'(1'b0));
    chk("rst_ferr",  256'(frame_err),    256'(1'b0));
  endtask

  // One byte exchange; returns the byte the master shifted in, then a 1-clk gap
  task automatic xchg(input logic [7:0] b, input logic done, input logic [127:0] dout,
                      output logic [7:0] got, output logic start_seen);
    got      = tx_data;
    rx_data  = b;
    rx_valid = 1'b1;
    aes_done = done;
    if (done) aes_block_out = dout;
    @(posedge clk); #1;
    start_seen = aes_start;
    rx_valid   = 1'b0;
    aes_done   = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_head(input logic [127:0] block, input logic [7:0] size_byte,
                           input logic [255:0] key, input int nkey, output logic last_start);
    logic [7:0] got;
    logic       st;
    for (int i = 0; i < 16; i++) begin
      xchg(block[(15-i)*8 +: 8], 1'b0, '0, got, st);
      if (i == 0) begin
        chk("busy_first", 256'(busy), 256'(1'b1));
        chk("ferr_clear", 256'(frame_err), 256'(1'b0));
      end
    end
    xchg(size_byte, 1'b0, '0, got, st);
    for (int i = 0; i < nkey; i++) xchg(key[(nkey-1-i)*8 +: 8], 1'b0, '0, got, st);
    last_start = st;
  endtask

  task automatic run_frame(input logic [127:0] block, input logic [7:0] size_byte,
                           input logic [255:0] key, input int polls, input logic done_rx,
                           input int reset_at);
    int           nkey;
    int           s0;
    logic [127:0] exp_res;
    logic [127:0] dout;
    logic [7:0]   got;
    logic         st;
    nkey    = int'(size_byte[6:0]);
    exp_res = core_fn(block, key, size_byte);
    s0      = start_count;
    cs_n = 1'b0;
    @(posedge clk); #1;
    send_head(block, size_byte, key, nkey, st);
    chk("start_pulse", 256'(st), 256'(1'b1));
    chk("key",   aes_key, key);
    chk("block", 256'(aes_block_in), 256'(block));
    chk("ksize", 256'(aes_key_size), 256'((nkey - 16) / 8));
    chk("dec",   256'(aes_decrypt), 256'(size_byte[7]));
    dout = core_fn(aes_block_in, aes_key, {aes_decrypt, 7'(16 + 8 * int'(aes_key_size))});
    for (int p = 0; p < polls; p++) begin
      xchg(8'h00, done_rx && (p == polls - 1), dout, got, st);
      chk("busy_poll", 256'(got), 256'(8'h00));
    end
    if (!done_rx) begin
      aes_block_out = dout;
      aes_done = 1'b1;
      @(posedge clk); #1;
      aes_done = 1'b0;
      @(posedge clk); #1;
    end
    xchg(8'h00, 1'b0, '0, got, st);
    chk("ready", 256'(got), 256'(8'h01));
    for (int i = 0; i < 16; i++) begin
      if (i == reset_at) begin
        reset = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b1;
        cs_n  = 1'b1;
        @(posedge clk); #1;
        return;
      end
      xchg(8'h00, 1'b0, '0, got, st);
      chk("res_byte", 256'(got), 256'(exp_res[(15-i)*8 +: 8]));
    end
    chk("idle_tx",   256'(tx_data), 256'(8'h00));
    chk("busy_end",  256'(busy), 256'(1'b0));
    chk("start_cnt", 256'(start_count - s0), 256'(1));
    cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_key(input int nkey);
    logic [255:0] k;
    logic [255:0] m;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    m = {256{1'b1}};
    m = m >> (256 - 8 * nkey);
    return k & m;
  endfunction

  function automatic int rand_nkey();
    case ($urandom_range(0, 2))
      0:       return 16;
      1:       return 24;
      default: return 32;
    endcase
  endfunction

  initial begin
    logic [127:0] blk;
    logic [255:0] key;
    logic [7:0]   got;
    logic [7:0]   bad [2];
    logic         st;
    int           nkey;
    int           s0;

    reset = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_data = '0;
    aes_done = 1'b0; aes_block_out = '0;

    kat[0] = '{128'h00112233445566778899aabbccddeeff, 8'h20,
               256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h8ea2b7ca516745bfeafc49904b496089};
    kat[1] = '{128'h00112233445566778899aabbccddeeff, 8'h10,
               256'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    kat[2] = '{128'h8ea2b7ca516745bfeafc49904b496089, 8'hA0,
               256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h00112233445566778899aabbccddeeff};
    kat[3] = '{128'h00112233445566778899aabbccddeeff, 8'h18,
               256'h000102030405060708090a0b0c0d0e0f1011121314151617,
               128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    kat[4] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 8'h90,
               256'h000102030405060708090a0b0c0d0e0f,
               128'h00112233445566778899aabbccddeeff};
    kat[5] = '{128'hdda97ca4864cdfe06eaf70a0ec0d7191, 8'h98,
               256'h000102030405060708090a0b0c0d0e0f1011121314151617,
               128'h00112233445566778899aabbccddeeff};

    #12;
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Known-answer frames
    for (int i = 0; i < 6; i++)
      run_frame(kat[i].block, kat[i].size_byte, kat[i].key, 1 + i % 3, 1'(i % 2), -1);

    // Random frames
    for (int n = 0; n < 10; n++) begin
      nkey = rand_nkey();
      blk  = {$urandom, $urandom, $urandom, $urandom};
      run_frame(blk, {1'($urandom_range(0, 1)), 7'(nkey)}, rand_key(nkey),
                $urandom_range(1, 4), 1'($urandom_range(0, 1)), -1);
    end

    // Bytes while deselected are ignored
    for (int i = 0; i < 3; i++) xchg(8'hA5, 1'b0, '0, got, st);
    chk("desel_busy", 256'(busy), 256'(1'b0));
    chk("desel_tx",   256'(tx_data), 256'(8'h00));

    // Bad size bytes
    bad[0] = 8'h11;
    bad[1] = 8'hA1;
    for (int b = 0; b < 2; b++) begin
      s0 = start_count;
      cs_n = 1'b0;
      @(posedge clk); #1;
      send_head(128'h0123456789abcdef0011223344556677, bad[b], '0, 0, st);
      chk("err_flag", 256'(frame_err), 256'(1'b1));
      for (int i = 0; i < 3; i++) begin
        xchg(8'h20, 1'b0, '0, got, st);
        chk("err_byte", 256'(got), 256'(8'hEE));
      end
      chk("err_nostart", 256'(start_count - s0), 256'(0));
      cs_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("err_idle_tx",  256'(tx_data), 256'(8'h00));
      chk("err_idle_bsy", 256'(busy), 256'(1'b0));
      chk("err_sticky",   256'(frame_err), 256'(1'b1));
      run_frame(kat[1].block, kat[1].size_byte, kat[1].key, 2, 1'b0, -1);
    end

    // Abort after 5 key bytes, then a full frame
    s0 = start_count;
    cs_n = 1'b0;
    @(posedge clk); #1;
    send_head(kat[0].block, 8'h20, kat[0].key, 5, st);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_nostart", 256'(start_count - s0), 256'(0));
    chk("abort_busy",    256'(busy), 256'(1'b0));
    run_frame(kat[0].block, kat[0].size_byte, kat[0].key, 2, 1'b1, -1);

    // Abort during CRYPT, late aes_done in IDLE must be ignored
    s0 = start_count;
    cs_n = 1'b0;
    @(posedge clk); #1;
    send_head(kat[1].block, 8'h10, kat[1].key, 16, st);
    cs_n = 1'b1;
    @(posedge clk); #1;
    aes_block_out = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    aes_done = 1'b1;
    @(posedge clk); #1;
    aes_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("late_done_tx",   256'(tx_data), 256'(8'h00));
    chk("late_done_busy", 256'(busy), 256'(1'b0));
    chk("late_start_cnt", 256'(start_count - s0), 256'(1));
    run_frame(kat[3].block, kat[3].size_byte, kat[3].key, 1, 1'b0, -1);

    // Reset asserted in the middle of the result bytes
    nkey = rand_nkey();
    run_frame({$urandom, $urandom, $urandom, $urandom}, 7'(nkey), rand_key(nkey), 2, 1'b0, 7);
    run_frame(kat[2].block, kat[2].size_byte, kat[2].key, 3, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
